// File: rtl/ram_bytelane_pipe.sv
// Byte-lane simple dual-port RAM with an optional output register, read-valid strobe,
// same-address write-to-read forwarding and out-of-range error reporting.
module ram_bytelane_pipe #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int OUT_REG    = 0,
    parameter int FORWARD    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    i_read_req,
    input  logic [ADDR_WIDTH-1:0]   i_read_addr,
    output logic                    o_read_valid,
    output logic [DATA_WIDTH-1:0]   o_read_data,
    output logic                    o_read_err,
    input  logic                    i_write_enable,
    input  logic [DATA_WIDTH/8-1:0] i_byte_enable,
    input  logic [ADDR_WIDTH-1:0]   i_write_addr,
    input  logic [DATA_WIDTH-1:0]   i_write_data,
    output logic                    o_write_err
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  rd_in_range;
    logic                  wr_in_range;
    logic                  rd_mem;
    logic                  wr_mem;
    logic                  collide;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic [LANES-1:0]      fwd_sel;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  s1_valid;
    logic                  s1_blank;
    logic [LANES-1:0]      s1_fwd;
    logic [DATA_WIDTH-1:0] s1_wdata;
    logic [DATA_WIDTH-1:0] s1_data;

    // Full-width compare so upper address bits never alias onto implemented words.
    assign rd_in_range = {1'b0, i_read_addr} < DEPTH_LIM;
    assign wr_in_range = {1'b0, i_write_addr} < DEPTH_LIM;
    assign rd_idx      = i_read_addr[IDX_W-1:0];
    assign wr_idx      = i_write_addr[IDX_W-1:0];
    assign rd_mem      = clk_en & i_read_req & rd_in_range;
    assign wr_mem      = clk_en & i_write_enable & wr_in_range;
    assign collide     = rd_mem & wr_mem & (i_read_addr == i_write_addr);
    assign fwd_sel     = (FORWARD != 0 && collide) ? i_byte_enable : '0;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_lane;

        always_ff @(posedge clk) begin
            if (wr_mem && i_byte_enable[k]) begin
                mem[wr_idx] <= i_write_data[8*k +: 8];
            end
        end

        // Read-before-write port register, kept reset-free so it maps onto the RAM macro.
        always_ff @(posedge clk) begin
            if (rd_mem) begin
                rd_lane <= mem[rd_idx];
            end
        end

        assign rd_word[8*k +: 8] = rd_lane;
    end

    // s1_blank forces zero data: set by reset and by out-of-range reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_blank <= 1'b1;
            s1_fwd   <= '0;
            s1_wdata <= '0;
        end else if (clk_en) begin
            s1_valid <= i_read_req;
            if (i_read_req) begin
                s1_blank <= ~rd_in_range;
                s1_fwd   <= fwd_sel;
                s1_wdata <= i_write_data;
            end
        end
    end

    always_comb begin
        s1_data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (!s1_blank) begin
                s1_data[8*k +: 8] = s1_fwd[k] ? s1_wdata[8*k +: 8] : rd_word[8*k +: 8];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  s2_valid;
        logic                  s2_err;
        logic [DATA_WIDTH-1:0] s2_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_err   <= 1'b0;
                s2_data  <= '0;
            end else if (clk_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_err  <= s1_blank;
                    s2_data <= s1_data;
                end
            end
        end

        assign o_read_valid = s2_valid;
        assign o_read_data  = s2_data;
        assign o_read_err   = s2_valid & s2_err;
    end else begin : g_no_out_reg
        assign o_read_valid = s1_valid;
        assign o_read_data  = s1_data;
        assign o_read_err   = s1_valid & s1_blank;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_write_err <= 1'b0;
        end else if (clk_en) begin
            o_write_err <= i_write_enable & ~wr_in_range;
        end
    end

endmodule

// File: tb/tb_ram_bytelane_pipe.sv
// Bench for ram_bytelane_pipe: two builds (OUT_REG=0/FORWARD=1 and OUT_REG=1/FORWARD=0)
// share stimulus; a reference memory feeds per-build scoreboards with data, error and latency.
module tb_ram_bytelane_pipe;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_en = 1'b1;
    logic          read_req = 1'b0;
    logic          write_enable = 1'b0;
    logic [AW-1:0] read_addr = '0;
    logic [AW-1:0] write_addr = '0;
    logic [3:0]    byte_enable = '0;
    logic [DW-1:0] write_data = '0;

    logic          va, ea, wea, vb, eb, web;
    logic [DW-1:0] da, db;

    always #5 clk = ~clk;

    ram_bytelane_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_REG(0), .FORWARD(1)) dut_a (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_read_req(read_req), .i_read_addr(read_addr),
        .o_read_valid(va), .o_read_data(da), .o_read_err(ea),
        .i_write_enable(write_enable), .i_byte_enable(byte_enable),
        .i_write_addr(write_addr), .i_write_data(write_data),
        .o_write_err(wea)
    );

    ram_bytelane_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_REG(1), .FORWARD(0)) dut_b (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_read_req(read_req), .i_read_addr(read_addr),
        .o_read_valid(vb), .o_read_data(db), .o_read_err(eb),
        .i_write_enable(write_enable), .i_byte_enable(byte_enable),
        .i_write_addr(write_addr), .i_write_data(write_data),
        .o_write_err(web)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] model [DEPTH];
    int          errors = 0;
    int          checks = 0;
    int          en_cyc = 0;
    logic        last_en = 1'b0;

    always @(posedge clk) begin
        last_en <= clk_en && !rst;
        if (clk_en && !rst) en_cyc <= en_cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (last_en && va) begin
            if (qa.size() == 0) begin
                chk("a_spurious_valid", 64'(va), 64'(0));
            end else begin
                e = qa.pop_front();
                chk("a_data", 64'(da), 64'(e.data));
                chk("a_err", 64'(ea), 64'(e.err));
                chk("a_latency", 64'(en_cyc - e.acc), 64'(0));
            end
        end
        if (last_en && vb) begin
            if (qb.size() == 0) begin
                chk("b_spurious_valid", 64'(vb), 64'(0));
            end else begin
                e = qb.pop_front();
                chk("b_data", 64'(db), 64'(e.data));
                chk("b_err", 64'(eb), 64'(e.err));
                chk("b_latency", 64'(en_cyc - e.acc), 64'(1));
            end
        end
    end

    // One clock of stimulus; expectations and the reference memory follow clk_en.
    task automatic cyc(input logic rr, input logic [AW-1:0] ra, input logic we,
                       input logic [3:0] be, input logic [AW-1:0] wa, input logic [31:0] wd);
        exp_t        xa;
        exp_t        xb;
        logic [31:0] old;
        read_req     = rr;
        read_addr    = ra;
        write_enable = we;
        byte_enable  = be;
        write_addr   = wa;
        write_data   = wd;
        if (clk_en && rr) begin
            xa.acc = en_cyc + 1;
            xb.acc = en_cyc + 1;
            if (ra < DEPTH) begin
                old     = model[ra[11:0]];
                xa.data = old;
                xb.data = old;
                xa.err  = 1'b0;
                xb.err  = 1'b0;
                if (we && wa == ra) begin
                    for (int k = 0; k < 4; k++) begin
                        if (be[k]) xa.data[8*k +: 8] = wd[8*k +: 8];
                    end
                end
            end else begin
                xa.data = '0;
                xb.data = '0;
                xa.err  = 1'b1;
                xb.err  = 1'b1;
            end
            qa.push_back(xa);
            qb.push_back(xb);
        end
        if (clk_en && we && wa < DEPTH) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) model[wa[11:0]][8*k +: 8] = wd[8*k +: 8];
            end
        end
        @(posedge clk);
        #1;
        read_req     = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 4'h0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_va", 64'(va), 64'(0));
        chk("rst_da", 64'(da), 64'(0));
        chk("rst_ea", 64'(ea), 64'(0));
        chk("rst_vb", 64'(vb), 64'(0));
        chk("rst_db", 64'(db), 64'(0));
        chk("rst_eb", 64'(eb), 64'(0));
        chk("rst_wea", 64'(wea), 64'(0));
        chk("rst_web", 64'(web), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Byte-lane write merge.
        cyc(1'b0, '0, 1'b1, 4'hF, 13'h000, 32'h600D_0000);
        cyc(1'b0, '0, 1'b1, 4'hF, 13'h020, 32'h0000_0000);
        cyc(1'b0, '0, 1'b1, 4'hF, 13'h010, 32'hDEAD_BEEF);
        cyc(1'b0, '0, 1'b1, 4'h5, 13'h010, 32'h1122_3344);
        cyc(1'b1, 13'h010, 1'b0, 4'h0, '0, '0);
        idle(2);

        // Back-to-back reads.
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 4'hF, 13'(i), 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) cyc(1'b1, 13'(i), 1'b0, 4'h0, '0, '0);
        idle(3);

        // Collision then follow-up read.
        cyc(1'b1, 13'h020, 1'b1, 4'h3, 13'h020, 32'hCAFE_F00D);
        cyc(1'b1, 13'h020, 1'b0, 4'h0, '0, '0);
        idle(3);

        // Range errors.
        cyc(1'b0, '0, 1'b1, 4'hF, 13'h1000, 32'hFFFF_FFFF);
        chk("werr_pulse_a", 64'(wea), 64'(1));
        chk("werr_pulse_b", 64'(web), 64'(1));
        idle(1);
        chk("werr_clear_a", 64'(wea), 64'(0));
        chk("werr_clear_b", 64'(web), 64'(0));
        cyc(1'b0, '0, 1'b1, 4'h0, 13'h1FFF, 32'h1234_5678);
        chk("werr_be0_a", 64'(wea), 64'(1));
        chk("werr_be0_b", 64'(web), 64'(1));
        cyc(1'b1, 13'h1000, 1'b0, 4'h0, '0, '0);
        cyc(1'b1, 13'h0000, 1'b0, 4'h0, '0, '0);
        idle(3);

        // Stall with a read in flight and a write presented while frozen.
        cyc(1'b1, 13'h010, 1'b0, 4'h0, '0, '0);
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, '0, 1'b1, 4'hF, 13'h010, 32'h0BAD_BAD0);
            chk("stall_vb_low", 64'(vb), 64'(0));
            chk("stall_va_hold", 64'(va), 64'(1));
        end
        clk_en = 1'b1;
        idle(2);
        cyc(1'b1, 13'h010, 1'b0, 4'h0, '0, '0);
        idle(3);

        // Asynchronous reset with reads in flight.
        cyc(1'b1, 13'h003, 1'b0, 4'h0, '0, '0);
        #2;
        rst = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        chk("arst_va", 64'(va), 64'(0));
        chk("arst_da", 64'(da), 64'(0));
        chk("arst_ea", 64'(ea), 64'(0));
        chk("arst_vb", 64'(vb), 64'(0));
        chk("arst_db", 64'(db), 64'(0));
        chk("arst_eb", 64'(eb), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(3);
        cyc(1'b1, 13'h003, 1'b0, 4'h0, '0, '0);
        cyc(1'b1, 13'h010, 1'b0, 4'h0, '0, '0);
        idle(3);

        chk("qa_drained", 64'(qa.size()), 64'(0));
        chk("qb_drained", 64'(qb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_bytelane_pipe.md
Name: ram_bytelane_pipe

Overview:
- Parametrised successor to the core's byte-lane scratch/instruction RAM.
- Simple dual-port memory: one write port, one read port.
  - Generic number of byte lanes.
  - Configurable read latency (optional output register).
  - Read-valid strobe.
  - Same-address write-to-read forwarding.
  - Out-of-range error reporting.
- Sits between the load/store unit and the bus fabric. Drop-in for the existing RAM when OUT_REG=0 and FORWARD=0.

Parameters:
- ADDR_WIDTH, 12, word-address bits on both ports.
- DATA_WIDTH, 32, data bits. Must be a multiple of 8; LANES = DATA_WIDTH/8.
- DEPTH, 4096, number of implemented words. Must be ≤ 2**ADDR_WIDTH.
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
- FORWARD, 1, 1 returns newly written bytes on a same-cycle, same-address read/write collision.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clk_en  in  1  global stall; 0 freezes all state including the pipeline.
- i_read_req  in  1  read request, sampled when clk_en=1.
- i_read_addr  in  ADDR_WIDTH  read word address.
- o_read_valid  out  1  o_read_data/o_read_err valid this cycle.
- o_read_data  out  DATA_WIDTH  read data.
- o_read_err  out  1  read address was ≥ DEPTH.
- i_write_enable  in  1  write request, sampled when clk_en=1.
- i_byte_enable  in  LANES  per-lane write enable; lane k is bits [8k+7:8k].
- i_write_addr  in  ADDR_WIDTH  write word address.
- i_write_data  in  DATA_WIDTH  write data.
- o_write_err  out  1  one-cycle pulse: previous write was dropped (address ≥ DEPTH).

Behaviour:
- Reset is asynchronous and active-high. On rst=1, immediately:
  - o_read_valid=0, o_read_err=0, o_write_err=0, o_read_data=0.
  - All pipeline valid bits cleared; any in-flight read is discarded and never reported.
  - Memory contents are not reset.
- The write port writes only the lanes whose i_byte_enable bit is 1; other lanes keep their contents.
- A write with i_byte_enable=0 is a no-op, but o_write_err is still reported if its address is out of range.
- Read latency:
  - OUT_REG=0: a request accepted at edge N gives o_read_valid=1 with data after edge N (one cycle).
  - OUT_REG=1: the result appears after edge N+1.
  - One result per accepted request, in order. A request may be accepted every cycle; no backpressure.
- o_read_valid is 1 only in cycles carrying a result; otherwise 0.
  - o_read_data holds its last value when o_read_valid=0. Verification checks it only when valid.
- Out-of-range read (addr ≥ DEPTH): o_read_data=0 and o_read_err=1, with the same latency and valid timing as a normal read. Memory is not accessed.
- Out-of-range write (addr ≥ DEPTH): no lane is written; o_write_err=1 for exactly one cycle after the accepting edge.
- Collision (read and write accepted at the same edge, same in-range address):
  - FORWARD=1: for each lane, if i_byte_enable[k]=1 return i_write_data lane k, else the old memory lane.
  - FORWARD=0: return old data for every lane (read-before-write).
- Write-then-read on consecutive cycles to the same address always returns the new data; no extra hazard logic is needed beyond the collision case.
- clk_en=0 freezes everything:
  - No memory write, no request acceptance.
  - Pipeline registers and all outputs hold, including o_read_valid, which stays 1 if it was 1.
  - o_write_err also holds.
  - Resuming clk_en=1 continues exactly where it stopped.
- Address bits above those needed for DEPTH participate in the range check; they are never truncated or aliased.
- Memory is inferred as LANES independent 8-bit-wide block RAM arrays of DEPTH words each. No reset path into the arrays.

Test Plan:
- Byte-lane write: reset; write addr 0x010 data 0xDEADBEEF be=4'b1111, then addr 0x010 data 0x11223344 be=4'b0101; read 0x010 -> o_read_valid one cycle later with data 0xDE22BE44, err=0.
- Latency/back-to-back: OUT_REG=1; fill addr 0..3 with 0xA0..0xA3; read requests on 4 consecutive cycles -> valid on cycles 2..5 after the first request, data 0xA0,0xA1,0xA2,0xA3 in order, no gaps.
- Collision: addr 0x020 holds 0x00000000; same edge write 0xCAFEF00D be=4'b0011 plus read 0x020 -> FORWARD=1 returns 0x0000F00D; FORWARD=0 returns 0x00000000; a read one cycle later returns 0x0000F00D in both builds.
- Range errors: DEPTH=4096, ADDR_WIDTH=13; write addr 0x1000 data 0xFFFFFFFF -> o_write_err pulses one cycle. Read addr 0x1000 -> valid, data 0, err=1. Read addr 0x0000 -> unchanged contents, err=0.
- Stall: OUT_REG=1; issue a read, drop clk_en for 5 cycles after the first edge -> no valid during the stall; valid appears one enabled edge after clk_en returns, with correct data. A write presented during the stall is not performed.
- Reset mid-operation: OUT_REG=1; issue a read, assert rst asynchronously mid-cycle before the result -> o_read_valid/o_read_data/o_read_err drop to 0 immediately. After release no stale valid appears, and memory contents written before reset read back intact.
